xgemac_tx_arbiter: RTL and testbench

- Packet-level round-robin arbiter that shares the single xge_mac TX packet interface (pkt_tx_*) between NUM_SRC requesters.
- Sits in the clk_156m25 domain directly in front of xge_mac; drives pkt_tx_data/val/sop/eop/mod and honours pkt_tx_full.
- Once granted, a source keeps the grant from sop through eop, so packets never interleave at the MAC.

---
 rtl/xgemac_tx_arbiter_pkg.sv | 11 +
 rtl/xgemac_rr_picker.sv | 27 ++
 rtl/xgemac_tx_arbiter.sv | 97 +++++++++
 tb/tb_xgemac_tx_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/xgemac_tx_arbiter_pkg.sv
// xgemac_package: shared state, beat and mod types for the xge_mac TX arbiter.
package xgemac_package;
   typedef enum logic {ARB_IDLE, ARB_XFER} arb_state_e;
   typedef struct packed {
      logic [63:0] data;
      logic        sop;
      logic        eop;
      logic [2:0]  mod;
   } xgemac_pkt_beat_t;
   localparam logic [2:0] XGEMAC_MOD_FULL = 3'd0;
endpackage

// File: rtl/xgemac_rr_picker.sv
// xgemac_rr_picker: round-robin priority encoder, searching ptr_i+1, ptr_i+2, ... modulo NUM_SRC.
module xgemac_rr_picker #(
   parameter  int NUM_SRC = 4,
   localparam int IW      = $clog2(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] req_i,
   input  logic [IW-1:0]      ptr_i,
   output logic [NUM_SRC-1:0] gnt_o,
   output logic [IW-1:0]      idx_o,
   output logic               vld_o
);
   always_comb begin
      int j;
      j     = 0;
      gnt_o = '0;
      idx_o = '0;
      vld_o = 1'b0;
      for (int k = 1; k <= NUM_SRC; k++) begin
         j = (int'(ptr_i) + k) % NUM_SRC;
         if (!vld_o && req_i[j]) begin
            vld_o    = 1'b1;
            gnt_o[j] = 1'b1;
            idx_o    = IW'(j);
         end
      end
   end
endmodule

// File: rtl/xgemac_tx_arbiter.sv
// xgemac_tx_arbiter: packet-level round-robin share of the xge_mac pkt_tx interface.
// Optional stall watchdog with forced eop: define XGEMAC_TX_ARB_WDOG_EN.
module xgemac_tx_arbiter
   import xgemac_package::*;
#(
   parameter int NUM_SRC     = 4,
   parameter int WDOG_CYCLES = 1024
) (
   input  logic                  clk_156m25,
   input  logic                  reset_156m25_n,
   input  logic [NUM_SRC*64-1:0] src_data,
   input  logic [NUM_SRC*3-1:0]  src_mod,
   input  logic [NUM_SRC-1:0]    src_val,
   input  logic [NUM_SRC-1:0]    src_sop,
   input  logic [NUM_SRC-1:0]    src_eop,
   output logic [NUM_SRC-1:0]    src_rdy,
   input  logic                  pkt_tx_full,
   output logic [63:0]           pkt_tx_data,
   output logic                  pkt_tx_val,
   output logic                  pkt_tx_sop,
   output logic                  pkt_tx_eop,
   output logic [2:0]            pkt_tx_mod,
   output logic [NUM_SRC-1:0]    arb_grant,
   output logic                  arb_proto_err,
   output logic                  arb_timeout
);
   localparam int IW = $clog2(NUM_SRC);
   arb_state_e       state_q;
   logic [NUM_SRC-1:0] grant_q, req, pick_gnt;
   logic [IW-1:0]    rr_q, pick_idx;
   logic             pick_vld, first_q, val_q, err_q, tmo_q, xfer, acc, fire;
   xgemac_pkt_beat_t beat_q, in_beat;
   // rr_q doubles as the owner index while in XFER
   assign xfer    = state_q == ARB_XFER;
   assign req     = src_val & src_sop;
   assign in_beat = '{data: src_data[int'(rr_q)*64 +: 64], sop: src_sop[rr_q],
                      eop: src_eop[rr_q], mod: src_mod[int'(rr_q)*3 +: 3]};
   xgemac_rr_picker #(.NUM_SRC(NUM_SRC)) u_picker (
      .req_i(req),
      .ptr_i(rr_q),
      .gnt_o(pick_gnt),
      .idx_o(pick_idx),
      .vld_o(pick_vld)
   );
`ifdef XGEMAC_TX_ARB_WDOG_EN
   logic [15:0] stall_q;
   logic        stall;
   assign stall = xfer && !src_val[rr_q] && !pkt_tx_full;
   assign fire  = stall && stall_q == 16'(WDOG_CYCLES - 1);
   always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
      if (!reset_156m25_n) stall_q <= '0;
      else stall_q <= (!xfer || acc || fire) ? '0 : stall_q + 16'(stall);
   end
`else
   assign fire = 1'b0;
`endif
   assign src_rdy = (xfer && !pkt_tx_full && !fire) ? grant_q : '0;
   assign acc     = |(src_val & src_rdy);
   always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
      if (!reset_156m25_n) begin
         state_q <= ARB_IDLE;
         grant_q <= '0;
         rr_q    <= IW'(NUM_SRC - 1);
         first_q <= 1'b0;
         beat_q  <= '0;
         val_q   <= 1'b0;
         err_q   <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         val_q <= acc || fire;
         err_q <= acc && ((in_beat.sop && !first_q) || (!in_beat.eop && in_beat.mod != XGEMAC_MOD_FULL));
         tmo_q <= fire;
         if (acc) begin
            beat_q  <= '{data: in_beat.data, sop: in_beat.sop, eop: in_beat.eop,
                         mod: in_beat.eop ? in_beat.mod : XGEMAC_MOD_FULL};
            first_q <= 1'b0;
         end else if (fire) beat_q <= '{data: '0, sop: 1'b0, eop: 1'b1, mod: XGEMAC_MOD_FULL};
         if (!xfer && pick_vld) begin
            state_q <= ARB_XFER;
            grant_q <= pick_gnt;
            rr_q    <= pick_idx;
            first_q <= 1'b1;
         end else if ((acc && in_beat.eop) || fire) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
         end
      end
   end
   assign pkt_tx_data   = beat_q.data;
   assign pkt_tx_sop    = beat_q.sop;
   assign pkt_tx_eop    = beat_q.eop;
   assign pkt_tx_mod    = beat_q.mod;
   assign pkt_tx_val    = val_q;
   assign arb_grant     = grant_q;
   assign arb_proto_err = err_q;
   assign arb_timeout   = tmo_q;
endmodule

// File: tb/tb_xgemac_tx_arbiter.sv
// tb_xgemac_tx_arbiter: directed checks of the TX arbiter with queue-fed sources.
// Watchdog expectations follow XGEMAC_TX_ARB_WDOG_EN (WDOG_CYCLES = 16).
module tb_xgemac_tx_arbiter;
   import xgemac_package::*;
   localparam int N = 4;
   logic           clk = 1'b0, rst_n = 1'b0;
   logic [N*64-1:0] src_data;
   logic [N*3-1:0]  src_mod;
   logic [N-1:0]    src_val, src_sop, src_eop, src_rdy, arb_grant;
   logic            pkt_tx_full, pkt_tx_val, pkt_tx_sop, pkt_tx_eop, arb_proto_err, arb_timeout;
   logic [63:0]     pkt_tx_data;
   logic [2:0]      pkt_tx_mod;
   xgemac_pkt_beat_t sq[N][$];
   xgemac_pkt_beat_t oq[$];
   logic [N-1:0]    gq[$];
   logic [N-1:0]    prev_g = '0;
   int n_chk = 0, n_pass = 0, n_err = 0, n_tmo = 0;

   always #5 clk = ~clk;

   xgemac_tx_arbiter #(.NUM_SRC(N), .WDOG_CYCLES(16)) dut (
      .clk_156m25(clk), .reset_156m25_n(rst_n),
      .src_data(src_data), .src_mod(src_mod), .src_val(src_val), .src_sop(src_sop),
      .src_eop(src_eop), .src_rdy(src_rdy), .pkt_tx_full(pkt_tx_full),
      .pkt_tx_data(pkt_tx_data), .pkt_tx_val(pkt_tx_val), .pkt_tx_sop(pkt_tx_sop),
      .pkt_tx_eop(pkt_tx_eop), .pkt_tx_mod(pkt_tx_mod), .arb_grant(arb_grant),
      .arb_proto_err(arb_proto_err), .arb_timeout(arb_timeout)
   );

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         if (sq[i].size() > 0) begin
            src_val[i] = 1'b1;
            src_sop[i] = sq[i][0].sop;
            src_eop[i] = sq[i][0].eop;
            src_data[i*64 +: 64] = sq[i][0].data;
            src_mod[i*3 +: 3] = sq[i][0].mod;
         end else begin
            src_val[i] = 1'b0;
            src_sop[i] = 1'b0;
            src_eop[i] = 1'b0;
            src_data[i*64 +: 64] = '0;
            src_mod[i*3 +: 3] = '0;
         end
      end
   endtask

   task automatic push(int s, logic [63:0] d, logic so, logic eo, logic [2:0] m);
      sq[s].push_back('{data: d, sop: so, eop: eo, mod: m});
   endtask

   task automatic clear();
      oq.delete();
      gq.delete();
      n_err = 0;
      n_tmo = 0;
   endtask

   task automatic wait_out(int n);
      for (int c = 0; c < 300 && oq.size() < n; c++) begin
         @(negedge clk);
         #1;
      end
      repeat (3) @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      for (int i = 0; i < N; i++) sq[i].delete();
      drive();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // sources: pop the front beat after each accepted handshake
   initial begin
      logic [N-1:0] acc;
      forever begin
         @(posedge clk);
         acc = src_val & src_rdy;
         #1;
         for (int i = 0; i < N; i++) if (acc[i] && sq[i].size() > 0) void'(sq[i].pop_front());
         drive();
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (pkt_tx_val) oq.push_back('{data: pkt_tx_data, sop: pkt_tx_sop, eop: pkt_tx_eop, mod: pkt_tx_mod});
            if (arb_proto_err) n_err++;
            if (arb_timeout) n_tmo++;
            if (arb_grant != '0 && prev_g == '0) gq.push_back(arb_grant);
            prev_g = arb_grant;
         end else prev_g = '0;
      end
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      int fire_c;
      logic [63:0] f_data;
      logic [2:0]  f_mod;
      logic        f_val, f_eop;
      pkt_tx_full = 1'b0;
      drive();
      repeat (2) @(negedge clk);
      #1;
      chk("rst_grant", arb_grant, 0);
      chk("rst_val", pkt_tx_val, 0);
      chk("rst_data", pkt_tx_data, 0);
      chk("rst_rdy", src_rdy, 0);
      chk("rst_err", arb_proto_err, 0);
      chk("rst_tmo", arb_timeout, 0);
      @(negedge clk);
      rst_n = 1'b1;
      // basic 3-beat packet from src0
      @(negedge clk);
      push(0, 64'h1111_1111_1111_1111, 1, 0, 0);
      push(0, 64'h2222_2222_2222_2222, 0, 0, 0);
      push(0, 64'h3333_3333_3333_3333, 0, 1, 5);
      drive();
      @(negedge clk);
      chk("t1_grant", arb_grant, 4'b0001);
      chk("t1_val_lat", pkt_tx_val, 0);
      chk("t1_rdy", src_rdy, 4'b0001);
      @(negedge clk);
      chk("t1_b1_val", pkt_tx_val, 1);
      chk("t1_b1_sop", pkt_tx_sop, 1);
      chk("t1_b1_data", pkt_tx_data, 64'h1111_1111_1111_1111);
      @(negedge clk);
      chk("t1_b2_data", pkt_tx_data, 64'h2222_2222_2222_2222);
      chk("t1_b2_sop", pkt_tx_sop, 0);
      @(negedge clk);
      chk("t1_b3_data", pkt_tx_data, 64'h3333_3333_3333_3333);
      chk("t1_b3_eop", pkt_tx_eop, 1);
      chk("t1_b3_mod", pkt_tx_mod, 5);
      chk("t1_grant_end", arb_grant, 0);
      @(negedge clk);
      chk("t1_gap", pkt_tx_val, 0);
      // round robin: two 2-beat packets queued at every source
      do_reset();
      clear();
      for (int r = 0; r < 2; r++)
         for (int s = 0; s < N; s++) begin
            push(s, 64'(s*256 + r*16), 1, 0, 0);
            push(s, 64'(s*256 + r*16 + 1), 0, 1, 0);
         end
      drive();
      wait_out(16);
      chk("rr_ngrants", gq.size(), 8);
      for (int k = 0; k < 8; k++) chk($sformatf("rr_grant%0d", k), k < gq.size() ? gq[k] : '0, 64'(1 << (k % 4)));
      chk("rr_nbeats", oq.size(), 16);
      for (int k = 0; k < 16; k++)
         chk($sformatf("rr_beat%0d", k), k < oq.size() ? {oq[k].data[15:0], oq[k].sop, oq[k].eop} : '1,
             {16'((k/2%4)*256 + (k/8)*16 + k%2), k%2 == 0, k%2 == 1});
      // backpressure: full held for 5 cycles after two beats
      clear();
      for (int b = 0; b < 5; b++) push(0, 64'hA0 + 64'(b), b == 0, b == 4, 0);
      drive();
      repeat (3) @(negedge clk);
      pkt_tx_full = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk($sformatf("bp_rdy%0d", c), src_rdy, 0);
         chk($sformatf("bp_val%0d", c), pkt_tx_val, 0);
      end
      pkt_tx_full = 1'b0;
      wait_out(5);
      chk("bp_nbeats", oq.size(), 5);
      for (int k = 0; k < 5; k++) chk($sformatf("bp_beat%0d", k), k < oq.size() ? oq[k].data : '1, 64'hA0 + 64'(k));
      // single-beat packet is legal
      clear();
      push(2, 64'hC2, 1, 1, 3);
      drive();
      wait_out(1);
      chk("sb_nbeats", oq.size(), 1);
      chk("sb_flags", oq.size() > 0 ? {oq[0].sop, oq[0].eop, oq[0].mod} : '1, {1'b1, 1'b1, 3'd3});
      chk("sb_err", n_err, 0);
      // second sop mid-packet
      clear();
      push(1, 64'hD0, 1, 0, 0);
      push(1, 64'hD1, 1, 0, 0);
      push(1, 64'hD2, 0, 1, 2);
      drive();
      wait_out(3);
      chk("sop2_nbeats", oq.size(), 3);
      chk("sop2_err", n_err, 1);
      chk("sop2_fwd", oq.size() > 1 ? {oq[1].data, oq[1].sop} : '1, {64'hD1, 1'b1});
      // nonzero mod on a non-eop beat
      clear();
      push(1, 64'hE0, 1, 0, 6);
      push(1, 64'hE1, 0, 1, 0);
      drive();
      wait_out(2);
      chk("mod_err", n_err, 1);
      chk("mod_forced", oq.size() > 0 ? oq[0].mod : '1, 0);
      chk("mod_eop", oq.size() > 1 ? oq[1].mod : '1, 0);
      // watchdog: src3 stalls after sop, src0 waits behind it
      clear();
      push(3, 64'hF0, 1, 0, 0);
      drive();
      for (int c = 0; c < 20 && arb_grant != 4'b1000; c++) @(negedge clk);
      chk("wd_grant3", arb_grant, 4'b1000);
      push(0, 64'h50, 1, 0, 0);
      push(0, 64'h51, 0, 1, 0);
      drive();
      @(negedge clk);
      chk("wd_sop_out", {pkt_tx_val, pkt_tx_sop, pkt_tx_data}, {1'b1, 1'b1, 64'hF0});
      fire_c = 0;
      {f_val, f_eop, f_data, f_mod} = '0;
      for (int c = 1; c <= 40 && fire_c == 0; c++) begin
         @(negedge clk);
         if (arb_timeout) begin
            fire_c = c;
            {f_val, f_eop, f_data, f_mod} = {pkt_tx_val, pkt_tx_eop, pkt_tx_data, pkt_tx_mod};
         end
      end
`ifdef XGEMAC_TX_ARB_WDOG_EN
      chk("wd_fire_cycle", fire_c, 16);
      chk("wd_synth_beat", {f_val, f_eop, f_data, f_mod}, {1'b1, 1'b1, 64'h0, 3'd0});
      @(negedge clk);
      chk("wd_next_grant", arb_grant, 4'b0001);
      wait_out(4);
      chk("wd_ntmo", n_tmo, 1);
`else
      chk("wd_no_fire", fire_c, 0);
      chk("wd_held", arb_grant, 4'b1000);
      chk("wd_synth_none", {f_val, f_eop, f_data, f_mod}, '0);
      push(3, 64'hF1, 0, 1, 0);
      drive();
      wait_out(4);
      chk("wd_ntmo", n_tmo, 0);
`endif
      chk("wd_nbeats", oq.size(), 4);
      // asynchronous reset during beat 2
      clear();
      push(0, 64'h60, 1, 0, 0);
      push(0, 64'h61, 0, 0, 0);
      push(0, 64'h62, 0, 1, 0);
      drive();
      repeat (2) @(negedge clk);
      chk("rm_pre_val", pkt_tx_val, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rm_val", pkt_tx_val, 0);
      chk("rm_grant", arb_grant, 0);
      chk("rm_data", pkt_tx_data, 0);
      chk("rm_rdy", src_rdy, 0);
      chk("rm_sop", pkt_tx_sop, 0);
      for (int i = 0; i < N; i++) sq[i].delete();
      drive();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      push(1, 64'h71, 1, 1, 0);
      push(0, 64'h70, 1, 1, 0);
      drive();
      @(negedge clk);
      chk("rm_first_win", arb_grant, 4'b0001);
      wait_out(2);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
